// File: rtl/nrm_nbit_pkg.sv
// Shared definitions for the sequential normalizer: FSM encoding and mode constants.
package nrm_nbit_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic MODE_UNSIGNED = 1'b0;
   localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/add_nbit.sv
// Plain N-bit adder, carry-out discarded (wraps modulo 2^N).
module add_nbit #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] s
);

   assign s = a + b;

endmodule

// File: rtl/nrm_detect.sv
// Combinational normalized-word detector for unsigned or two's-complement operands.
module nrm_detect
   import nrm_nbit_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] word,
   input  logic         mode,
   output logic         normalized
);

   // Signed words are normalized once the sign bit differs from the bit below it.
   assign normalized = (mode == MODE_SIGNED) ? (word[N-1] != word[N-2]) : word[N-1];

endmodule

// File: rtl/nrm_nbit.sv
// Sequential normalizer: left-shifts an operand one bit per clock until normalized,
// then reports the normalized value, the shift count and an all-zero flag.
module nrm_nbit
   import nrm_nbit_pkg::*;
#(
   parameter int unsigned N = 8,
   parameter int unsigned M = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         mode,
   input  logic [N-1:0] x,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] r,
   output logic [M-1:0] cnt,
   output logic         zero
);

   state_t       state;
   state_t       state_nxt;
   logic [N-1:0] work;
   logic         work_mode;
   logic [M-1:0] count;
   logic [M-1:0] count_inc;
   logic         norm;

   nrm_detect #(.N(N)) u_detect (
      .word       (work),
      .mode       (work_mode),
      .normalized (norm)
   );

   add_nbit #(.N(M)) u_inc (
      .a (count),
      .b (M'(1)),
      .s (count_inc)
   );

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (x == '0) ? DONE : SHIFT;
         SHIFT:   if (norm) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         work      <= '0;
         work_mode <= MODE_UNSIGNED;
         count     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         r         <= '0;
         cnt       <= '0;
         zero      <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
         done  <= (state_nxt == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  work      <= x;
                  work_mode <= mode;
                  count     <= '0;
                  if (x == '0) begin
                     r    <= '0;
                     cnt  <= '0;
                     zero <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               if (norm) begin
                  r    <= work;
                  cnt  <= count;
                  zero <= 1'b0;
               end else begin
                  work  <= {work[N-2:0], 1'b0};
                  count <= count_inc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nrm_nbit.sv
// Scoreboard bench for nrm_nbit (N=8, M=3).
module tb_nrm_nbit;

   typedef struct packed {
      logic [7:0] r;
      logic [2:0] cnt;
      logic       zero;
      logic [7:0] lat;
   } res_t;

   logic       clk;
   logic       rst;
   logic       start;
   logic       mode;
   logic [7:0] x;
   logic       busy;
   logic       done;
   logic [7:0] r;
   logic [2:0] cnt;
   logic       zero;

   int n_cmp = 0;
   int n_bad = 0;
   res_t sb[$];

   nrm_nbit #(.N(8), .M(3)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .mode  (mode),
      .x     (x),
      .busy  (busy),
      .done  (done),
      .r     (r),
      .cnt   (cnt),
      .zero  (zero)
   );

   always #5 clk = ~clk;

   function automatic res_t model(input logic m, input logic [7:0] v);
      res_t e;
      logic [7:0] w;
      int k;
      w = v;
      k = 0;
      if (v == 8'h00) begin
         e.r = 8'h00; e.cnt = 3'd0; e.zero = 1'b1; e.lat = 8'd1;
      end else begin
         while (!(m ? (w[7] ^ w[6]) : w[7])) begin
            w = w << 1;
            k++;
         end
         e.r = w; e.cnt = 3'(k); e.zero = 1'b0; e.lat = 8'(k + 2);
      end
      return e;
   endfunction

   function automatic res_t mk(input logic [7:0] rr, input int c, input logic z, input int l);
      res_t e;
      e.r = rr; e.cnt = 3'(c); e.zero = z; e.lat = 8'(l);
      return e;
   endfunction

   // Push expectation, pulse start across one rising edge; returns at the negedge after it.
   task automatic issue(input logic m, input logic [7:0] v, input res_t e);
      sb.push_back(e);
      @(negedge clk);
      start = 1'b1; mode = m; x = v;
      @(negedge clk);
      start = 1'b0;
      x = ~v;
      mode = ~m;
   endtask

   // Wait (bounded) for done; optionally re-pulse start mid-operation at cycle 'poke'.
   task automatic collect(input int poke, input logic [7:0] px, output res_t got);
      int lat;
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
         if (lat == poke) begin
            start = 1'b1; x = px; mode = ~mode;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      got.r = r; got.cnt = cnt; got.zero = zero; got.lat = 8'(lat);
   endtask

   task automatic pop_cmp(input string name, input res_t got);
      res_t e;
      n_cmp++;
      if (sb.size() == 0) begin
         n_bad++;
         $display("FAIL %s: scoreboard empty, got r=%h cnt=%0d zero=%b lat=%0d",
                  name, got.r, got.cnt, got.zero, got.lat);
      end else begin
         e = sb.pop_front();
         if (got !== e) begin
            n_bad++;
            $display("FAIL %s: got r=%h cnt=%0d zero=%b lat=%0d, want r=%h cnt=%0d zero=%b lat=%0d",
                     name, got.r, got.cnt, got.zero, got.lat, e.r, e.cnt, e.zero, e.lat);
         end
      end
   endtask

   task automatic test_reset();
      #1;
      n_cmp++;
      if ({busy, done, r, cnt, zero} !== 14'd0) begin
         n_bad++;
         $display("FAIL reset_hold: got %h want 0", {busy, done, r, cnt, zero});
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({busy, done, r, cnt, zero} !== 14'd0) begin
         n_bad++;
         $display("FAIL reset_release: got %h want 0", {busy, done, r, cnt, zero});
      end
   endtask

   task automatic test_unsigned();
      res_t got;
      issue(1'b0, 8'h01, mk(8'h80, 7, 1'b0, 9));
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL busy_in_shift: got %b want 1", busy);
      end
      collect(0, 8'h00, got); pop_cmp("u_01", got);
      @(negedge clk);
      n_cmp++;
      if ({done, busy} !== 2'b00) begin
         n_bad++;
         $display("FAIL done_one_cycle: got done/busy=%b want 00", {done, busy});
      end
      issue(1'b0, 8'h80, mk(8'h80, 0, 1'b0, 2));
      collect(0, 8'h00, got); pop_cmp("u_80", got);
      issue(1'b0, 8'h35, mk(8'hD4, 2, 1'b0, 4));
      collect(0, 8'h00, got); pop_cmp("u_35", got);
      repeat (5) @(negedge clk);
      n_cmp++;
      if ({r, cnt, zero} !== {8'hD4, 3'd2, 1'b0}) begin
         n_bad++;
         $display("FAIL hold_after_done: got r=%h cnt=%0d zero=%b want r=d4 cnt=2 zero=0", r, cnt, zero);
      end
   endtask

   task automatic test_signed();
      res_t got;
      issue(1'b1, 8'h03, mk(8'h60, 5, 1'b0, 7)); collect(0, 8'h00, got); pop_cmp("s_03", got);
      issue(1'b1, 8'hFF, mk(8'h80, 7, 1'b0, 9)); collect(0, 8'h00, got); pop_cmp("s_ff", got);
      issue(1'b1, 8'hC0, mk(8'h80, 1, 1'b0, 3)); collect(0, 8'h00, got); pop_cmp("s_c0", got);
      issue(1'b1, 8'h40, mk(8'h40, 0, 1'b0, 2)); collect(0, 8'h00, got); pop_cmp("s_40", got);
      issue(1'b1, 8'hB5, mk(8'hB5, 0, 1'b0, 2)); collect(0, 8'h00, got); pop_cmp("s_b5", got);
   endtask

   task automatic test_zero();
      res_t got;
      issue(1'b0, 8'h00, mk(8'h00, 0, 1'b1, 1)); collect(0, 8'h00, got); pop_cmp("z_uns", got);
      issue(1'b1, 8'h00, mk(8'h00, 0, 1'b1, 1)); collect(0, 8'h00, got); pop_cmp("z_sgn", got);
      // A nonzero result afterwards must clear the zero flag
      issue(1'b0, 8'h02, mk(8'h80, 6, 1'b0, 8)); collect(0, 8'h00, got); pop_cmp("z_clear", got);
   endtask

   task automatic test_busy_start();
      res_t got;
      int extra;
      issue(1'b0, 8'h01, mk(8'h80, 7, 1'b0, 9));
      collect(3, 8'h40, got); pop_cmp("busy_start_result", got);
      extra = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) extra++;
      end
      n_cmp++;
      if (extra !== 0) begin
         n_bad++;
         $display("FAIL busy_start_pulses: got %0d extra done pulses want 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      res_t got;
      issue(1'b0, 8'h80, mk(8'h80, 0, 1'b0, 2));
      collect(0, 8'h00, got); pop_cmp("b2b_first", got);
      // Start raised in the DONE cycle is ignored and taken in the following IDLE cycle
      sb.push_back(mk(8'h80, 2, 1'b0, 4));
      start = 1'b1; mode = 1'b0; x = 8'h20;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_idle_gap: got busy=%b want 0", busy);
      end
      @(negedge clk);
      start = 1'b0;
      collect(0, 8'h00, got); pop_cmp("b2b_second", got);
   endtask

   task automatic test_reset_mid();
      res_t got;
      int pulses;
      @(negedge clk);
      start = 1'b1; mode = 1'b0; x = 8'h01;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy, done, r, cnt, zero} !== 14'd0) begin
         n_bad++;
         $display("FAIL reset_mid: got busy=%b done=%b r=%h cnt=%0d zero=%b want all 0",
                  busy, done, r, cnt, zero);
      end
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      n_cmp++;
      if (pulses !== 0) begin
         n_bad++;
         $display("FAIL reset_mid_no_done: got %0d done pulses want 0", pulses);
      end
      issue(1'b0, 8'h10, mk(8'h80, 3, 1'b0, 5));
      collect(0, 8'h00, got); pop_cmp("reset_mid_next", got);
   endtask

   task automatic test_random();
      res_t got;
      logic m;
      logic [7:0] v;
      for (int i = 0; i < 10; i++) begin
         m = 1'($urandom_range(0, 1));
         v = 8'($urandom_range(0, 255));
         issue(m, v, model(m, v));
         collect(0, 8'h00, got);
         pop_cmp("random", got);
      end
   endtask

   initial begin
      clk = 1'b0; rst = 1'b1; start = 1'b0; mode = 1'b0; x = 8'h00;
      test_reset();
      test_unsigned();
      test_signed();
      test_zero();
      test_busy_start();
      test_back_to_back();
      test_reset_mid();
      test_random();
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
